fwd_ctrl: RTL
=============

// Module: fwd_ctrl
// PURPOSE
//  Forwarding/hazard controller that feeds the 3-way 16-bit operand muxes in EX.
//  Tracks dest regs of instructions in EX, MEM, WB; per operand, registers a 2-bit
//  select aligned with the instruction entering EX. Detects load-use hazards and
//  stalls ID one cycle. Keeps saturating stall and forward event counters.
// PARAMETERS
//  REG_ADDR_W  4   register address width (16 architectural regs)
//  ZERO_REG    1   1: reg 0 is hardwired zero and is never forwarded
//  CNT_W       16  width of the perf counters
// PORTS
//  clk          in   1           rising-edge clock
//  rst          in   1           synchronous, active-high reset
//  id_valid     in   1           ID holds a valid instruction
//  id_rs_a      in   REG_ADDR_W  source reg for operand A
//  id_rs_b      in   REG_ADDR_W  source reg for operand B
//  id_rd        in   REG_ADDR_W  destination reg
//  id_wr_en     in   1           instruction writes id_rd
//  id_is_load   in   1           instruction is a memory load
//  flush        in   1           branch taken in EX: kill ID instruction
//  stall        out  1           hold PC/IF/ID this cycle (combinational)
//  ex_sel_a     out  2           operand A mux select for instr in EX
//  ex_sel_b     out  2           operand B mux select for instr in EX
//  stall_count  out  CNT_W       load-use stalls seen, saturating
//  fwd_count    out  CNT_W       operands forwarded (non-00 sel), saturating
// BEHAVIOUR
//  Select encoding (fixed by EX mux): 2'b00 = regfile value (in1),
//   2'b10 = EX/MEM ALU result (in2), 2'b01 = MEM/WB writeback value (in3); 2'b11 never driven.
//  State: three stage entries EX, MEM, WB = {valid, wr_en, is_load, rd}.
//  Each edge: WB<=MEM, MEM<=EX, EX<=ID entry or bubble (valid=0).
//  Bubble into EX when !id_valid, stall, or flush.
//  Producer match for reg r in stage S: S.valid & S.wr_en & S.rd==r
//   & !(ZERO_REG & r==0).
//  Select computed from pre-edge state, registered with the EX entry:
//   match(EX) -> 2'b10 (producer will be in MEM); else match(MEM) -> 2'b01; else 2'b00.
//   Youngest producer wins (EX over MEM). Bubble in EX -> both sels 2'b00.
//  stall = id_valid & !flush & EX.valid & EX.wr_en & EX.is_load
//          & (match rs_a or rs_b to EX.rd, zero-reg rule applied).
//  Stall lasts exactly 1 cycle: next cycle the load is in MEM, so the select is 2'b01.
//  flush has priority over stall: stall=0 and a bubble is inserted.
//  Load with no consumer: no stall.
//  Two consecutive loads to the same rd: the younger one governs.
//  stall_count +1 per stall cycle; fwd_count += number of non-00 sels loaded
//   (0, 1 or 2) per edge. Both saturate at all-ones and do not wrap.
//  Reset (rst high at edge): all entries invalid, ex_sel_a/b=00, counters=0,
//   stall=0. Reset mid-hazard drops pending stall; next ID instr sees sel 00.
//  Latency: ex_sel_* valid 1 cycle after ID instr accepted (aligned with EX).
// TESTING
//  1 rst 2 cycles -> sels 00, stall 0, both counts 0.
//  2 ADD r3 then ADD r4<-r3,r5 back-to-back -> 2nd in EX: ex_sel_a=10, ex_sel_b=00,
//    fwd_count=1.
//  3 ADD r3, NOP, SUB r6<-r2,r3 -> SUB in EX: ex_sel_b=01.
//    ADD r3; ADD r3; ADD r7<-r3 -> sel 10 (youngest wins).
//  4 LD r2 then ADD r1<-r2,r2 -> stall=1 for exactly 1 cycle, bubble in EX,
//    then ADD in EX with sel_a=sel_b=01, stall_count=1, fwd_count=2.
//  5 LD r2 then ADD r1<-r2 with flush=1 same cycle -> stall=0, bubble, sels 00.
//    Consumer of r0 after write to r0 -> sel 00.
//  6 force 65535 forwards -> fwd_count holds 16'hFFFF;
//    rst asserted during a stall -> stall=0 next cycle, counts cleared.

Source files
------------

// File: rtl/fwd_ctrl_if.sv
// Forwarding-controller bus: ID-stage instruction fields in, hazard/select/counters out.
// master = pipeline side driving ID fields, slave = fwd_ctrl.
interface fwd_ctrl_if #(
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 16
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs_a;
    logic [REG_ADDR_W-1:0] id_rs_b;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_wr_en;
    logic                  id_is_load;
    logic                  flush;
    logic                  stall;
    logic [1:0]            ex_sel_a;
    logic [1:0]            ex_sel_b;
    logic [CNT_W-1:0]      stall_count;
    logic [CNT_W-1:0]      fwd_count;

    modport master (
        output id_valid, id_rs_a, id_rs_b, id_rd, id_wr_en, id_is_load, flush,
        input  stall, ex_sel_a, ex_sel_b, stall_count, fwd_count
    );

    modport slave (
        input  id_valid, id_rs_a, id_rs_b, id_rd, id_wr_en, id_is_load, flush,
        output stall, ex_sel_a, ex_sel_b, stall_count, fwd_count
    );
endinterface

// File: rtl/fwd_ctrl.sv
// Purpose: EX operand-forwarding selects, load-use stall detection, saturating perf counters.
// Latency: ex_sel_* registered, valid 1 cycle after ID accept; stall is combinational.
// Backpressure: stall holds ID for exactly one cycle on a load-use hazard; flush overrides it.
module fwd_ctrl #(
    parameter int REG_ADDR_W = 4,
    parameter int ZERO_REG   = 1,
    parameter int CNT_W      = 16
) (
    input logic      clk,
    input logic      rst,
    fwd_ctrl_if.slave bus
);
    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b10;  // EX/MEM ALU result
    localparam logic [1:0] SEL_WB  = 2'b01;  // MEM/WB writeback value

    typedef struct packed {
        logic                  valid;
        logic                  wr_en;
        logic                  is_load;
        logic [REG_ADDR_W-1:0] rd;
    } stage_t;

    stage_t ex_q, mem_q, wb_q;
    stage_t id_entry, ex_nxt;

    logic [1:0]       sel_a_q, sel_b_q;
    logic [1:0]       sel_a_nxt, sel_b_nxt;
    logic [CNT_W-1:0] stall_cnt_q, fwd_cnt_q;
    logic             stall_int;
    logic             bubble;
    logic [1:0]       n_fwd;
    logic [CNT_W:0]   fwd_sum;

    function automatic logic producer_match(input stage_t s, input logic [REG_ADDR_W-1:0] r);
        return s.valid && s.wr_en && (s.rd == r) && !((ZERO_REG != 0) && (r == '0));
    endfunction

    function automatic logic [1:0] pick_sel(input stage_t ex_s, input stage_t mem_s,
                                            input logic [REG_ADDR_W-1:0] r);
        if (producer_match(ex_s, r))
            return SEL_MEM;
        else if (producer_match(mem_s, r))
            return SEL_WB;
        else
            return SEL_RF;
    endfunction

    always_comb begin
        stall_int = bus.id_valid && !bus.flush && ex_q.is_load &&
                    (producer_match(ex_q, bus.id_rs_a) || producer_match(ex_q, bus.id_rs_b));
        bubble    = !bus.id_valid || stall_int || bus.flush;

        id_entry.valid   = 1'b1;
        id_entry.wr_en   = bus.id_wr_en;
        id_entry.is_load = bus.id_is_load;
        id_entry.rd      = bus.id_rd;
        ex_nxt           = bubble ? '0 : id_entry;

        sel_a_nxt = bubble ? SEL_RF : pick_sel(ex_q, mem_q, bus.id_rs_a);
        sel_b_nxt = bubble ? SEL_RF : pick_sel(ex_q, mem_q, bus.id_rs_b);

        n_fwd   = {1'b0, sel_a_nxt != SEL_RF} + {1'b0, sel_b_nxt != SEL_RF};
        fwd_sum = {1'b0, fwd_cnt_q} + {{(CNT_W-1){1'b0}}, n_fwd};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            sel_a_q     <= SEL_RF;
            sel_b_q     <= SEL_RF;
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            wb_q    <= mem_q;
            mem_q   <= ex_q;
            ex_q    <= ex_nxt;
            sel_a_q <= sel_a_nxt;
            sel_b_q <= sel_b_nxt;
            if (stall_int && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 1'b1;
            // Carry out of the widened sum means the counter would wrap: clamp instead.
            fwd_cnt_q <= fwd_sum[CNT_W] ? '1 : fwd_sum[CNT_W-1:0];
        end
    end

    assign bus.stall       = stall_int;
    assign bus.ex_sel_a    = sel_a_q;
    assign bus.ex_sel_b    = sel_b_q;
    assign bus.stall_count = stall_cnt_q;
    assign bus.fwd_count   = fwd_cnt_q;

endmodule
